// File: rtl/mdu_if.sv
// Handshake and result bus between the multicycle control FSM and the
// sequential multiply/divide unit.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] param1;
  logic [WIDTH-1:0] param2;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, param1, param2,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, param1, param2,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit per cycle,
// plus single-cycle MTHI/MTLO writes.
// Optional feature macro: MDU_SIGNED_EN enables signed MULT/DIV (ops 001/011);
// when undefined those ops execute as MULTU/DIVU.
module mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // Latched operation context
  logic             is_div_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0] mcand_q;   // multiplicand or divisor magnitude
  logic [WIDTH:0]   rem_q;     // upper product half or partial remainder
  logic [WIDTH-1:0] qr_q;      // multiplier / dividend shifting out, low product / quotient in

  logic accept, mthi, mtlo, finish;
  logic sgn_op, s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff, rem_n;
  logic             div_ok;
  logic [WIDTH-1:0] qr_n, quot, remd, wb_hi, wb_lo;
  logic [PW-1:0]    prod;

`ifdef MDU_SIGNED_EN
  assign sgn_op = bus.op[0];
`else
  assign sgn_op = 1'b0;
`endif

  // Operand signs and magnitudes captured at acceptance
  assign s1   = sgn_op & bus.param1[WIDTH-1];
  assign s2   = sgn_op & bus.param2[WIDTH-1];
  assign mag1 = s1 ? -bus.param1 : bus.param1;
  assign mag2 = s2 ? -bus.param2 : bus.param2;

  // Next-state and control strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            accept  = 1'b1;
            state_d = RUN;
          end else if (!bus.op[1]) begin
            mthi = ~bus.op[0];
            mtlo = bus.op[0];
          end
        end
      end
      RUN: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = rem_q + {1'b0, (qr_q[0] ? mcand_q : '0)};
    div_shift = {rem_q[WIDTH-1:0], qr_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_ok    = (div_shift >= {1'b0, mcand_q});
    if (is_div_q) begin
      rem_n = div_ok ? div_diff : div_shift;
      qr_n  = {qr_q[WIDTH-2:0], div_ok};
    end else begin
      rem_n = {1'b0, mul_sum[WIDTH:1]};
      qr_n  = {mul_sum[0], qr_q[WIDTH-1:1]};
    end
  end

  // Writeback values with sign fixup; divide-by-zero forces quotient to all ones
  always_comb begin
    prod = {rem_n[WIDTH-1:0], qr_n};
    if (neg_res_q) prod = -prod;
    quot = neg_res_q ? -qr_n : qr_n;
    remd = neg_rem_q ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
    if (is_div_q) begin
      wb_hi = remd;
      wb_lo = (mcand_q == '0) ? '1 : quot;
    end else begin
      wb_hi = prod[PW-1:WIDTH];
      wb_lo = prod[WIDTH-1:0];
    end
  end

  // FSM state, step counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= finish;
      if (accept)              cnt_q <= '0;
      else if (state_q == RUN) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Datapath, HI/LO and divide-by-zero flag
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      rem_q     <= '0;
      qr_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      if (accept) begin
        is_div_q  <= bus.op[1];
        neg_res_q <= s1 ^ s2;
        neg_rem_q <= s1;
        mcand_q   <= mag2;
        rem_q     <= '0;
        qr_q      <= mag1;
        dz_q      <= 1'b0;
      end else if (state_q == RUN) begin
        rem_q <= rem_n;
        qr_q  <= qr_n;
      end
      if (finish) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
        dz_q <= is_div_q & (mcand_q == '0);
      end
      if (mthi) hi_q <= bus.param1;
      if (mtlo) lo_q <= bus.param1;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq (WIDTH=32) with a result scoreboard.
module tb_mdu_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();
  mdu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } res_t;

  res_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model built on native 64-bit arithmetic
  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sbv;
    logic [63:0] p;
    bit sgn;
`ifdef MDU_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    r.dz = 1'b0;
    if (!op[1]) begin
      if (sgn) p = 64'(sa * sbv);
      else     p = 64'(a) * 64'(b);
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == 32'd0) begin
      r.hi = a;
      r.lo = '1;
      r.dz = 1'b1;
    end else if (sgn) begin
      p = 64'(sa / sbv);
      r.lo = p[31:0];
      p = 64'(sa % sbv);
      r.hi = p[31:0];
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  // Drive a mul/div for one accepting edge, record expectation, scramble inputs after
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(op, a, b));
    bus.start = 1'b1;
    bus.op = op;
    bus.param1 = a;
    bus.param2 = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.param1 = $urandom;
    bus.param2 = $urandom;
  endtask

  // Wait (bounded) for done; returns sampled result and busy-cycle count
  task automatic wait_done(output res_t got, output int bcyc, output bit tmo);
    tmo = 1'b1;
    bcyc = 0;
    got = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got.hi = bus.hi;
        got.lo = bus.lo;
        got.dz = bus.div_by_zero;
        tmo = 1'b0;
        break;
      end
      if (bus.busy) bcyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.param1 = '0;
    bus.param2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
    end
  endtask

  task automatic test_multu();
    res_t got, exp;
    int bc;
    bit tmo;
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(got, bc, tmo);
    exp = exp_q.pop_front();
    n_cmp++;
    if (tmo) begin n_err++; $display("FAIL multu_timeout: no done within bound"); end
    n_cmp++;
    if (got !== exp || got.hi !== 32'hFFFF_FFFE || got.lo !== 32'h1) begin
      n_err++;
      $display("FAIL multu_max: got hi=%h lo=%h want hi=fffffffe lo=00000001", got.hi, got.lo);
    end
    n_cmp++;
    if (bc !== 32) begin n_err++; $display("FAIL multu_busy_len: got %0d want 32", bc); end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== exp.hi || bus.lo !== exp.lo) begin
      n_err++;
      $display("FAIL multu_after_done: got done=%b busy=%b hi=%h lo=%h want done=0 busy=0 hi=%h lo=%h",
               bus.done, bus.busy, bus.hi, bus.lo, exp.hi, exp.lo);
    end
  endtask

  task automatic test_mult();
    logic [2:0]  ops[4] = '{3'b001, 3'b001, 3'b000, 3'b001};
    logic [31:0] as[4]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd123456, 32'h7FFF_FFFF};
    logic [31:0] bs[4]  = '{32'd5, 32'hFFFF_FFFF, 32'd654321, 32'h8000_0001};
    res_t got, exp;
    int bc;
    bit tmo;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) issue(ops[i], as[i], bs[i]);
      else issue({2'b00, 1'($urandom)}, $urandom, $urandom);
      wait_done(got, bc, tmo);
      exp = exp_q.pop_front();
      n_cmp++;
      if (tmo || got !== exp) begin
        n_err++;
        $display("FAIL mult_%0d: got hi=%h lo=%h tmo=%b want hi=%h lo=%h", i, got.hi, got.lo, tmo, exp.hi, exp.lo);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[4] = '{3'b011, 3'b011, 3'b010, 3'b011};
    logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd1000, 32'd17};
    logic [31:0] bs[4]  = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFB};
    res_t got, exp;
    int bc;
    bit tmo;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) issue(ops[i], as[i], bs[i]);
      else issue({2'b01, 1'($urandom)}, $urandom, (i == 7) ? $urandom : $urandom_range(1, 5000));
      wait_done(got, bc, tmo);
      exp = exp_q.pop_front();
      n_cmp++;
      if (tmo || got !== exp) begin
        n_err++;
        $display("FAIL div_%0d: got hi=%h lo=%h dz=%b tmo=%b want hi=%h lo=%h dz=%b",
                 i, got.hi, got.lo, got.dz, tmo, exp.hi, exp.lo, exp.dz);
      end
    end
  endtask

  task automatic test_divzero();
    res_t got, exp;
    int bc;
    bit tmo;
    issue(3'b010, 32'd100, 32'd0);
    wait_done(got, bc, tmo);
    exp = exp_q.pop_front();
    n_cmp++;
    if (tmo || got !== exp || got.lo !== 32'hFFFF_FFFF || got.hi !== 32'd100 || got.dz !== 1'b1) begin
      n_err++;
      $display("FAIL divu_zero: got hi=%h lo=%h dz=%b want hi=00000064 lo=ffffffff dz=1", got.hi, got.lo, got.dz);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_hold: got %b want 1", bus.div_by_zero); end
    issue(3'b000, 32'd3, 32'd4);
    n_cmp++;
    if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_clear_on_accept: got %b want 0", bus.div_by_zero); end
    wait_done(got, bc, tmo);
    exp = exp_q.pop_front();
    n_cmp++;
    if (tmo || got !== exp) begin
      n_err++;
      $display("FAIL multu_after_dz: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b", got.hi, got.lo, got.dz, exp.hi, exp.lo, exp.dz);
    end
    issue(3'b011, 32'hFFFF_FFFB, 32'd0);
    wait_done(got, bc, tmo);
    exp = exp_q.pop_front();
    n_cmp++;
    if (tmo || got !== exp) begin
      n_err++;
      $display("FAIL div_signed_zero: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b", got.hi, got.lo, got.dz, exp.hi, exp.lo, exp.dz);
    end
  endtask

  task automatic test_start_ignored();
    res_t got, exp;
    int bc;
    bit tmo;
    issue(3'b000, 32'd6, 32'd7);
    exp_q.push_back(model(3'b010, 32'd1000, 32'd7));
    bus.start = 1'b1;
    bus.op = 3'b010;
    bus.param1 = 32'd1000;
    bus.param2 = 32'd7;
    wait_done(got, bc, tmo);
    exp = exp_q.pop_front();
    n_cmp++;
    if (tmo || got.hi !== 32'd0 || got.lo !== 32'd42 || got !== exp) begin
      n_err++;
      $display("FAIL start_ignored_in_run: got hi=%h lo=%h want hi=00000000 lo=0000002a", got.hi, got.lo);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL accept_in_done_cycle: got busy=%b want 1", bus.busy); end
    wait_done(got, bc, tmo);
    exp = exp_q.pop_front();
    n_cmp++;
    if (tmo || got !== exp) begin
      n_err++;
      $display("FAIL divu_after_hold: got hi=%h lo=%h want hi=%h lo=%h", got.hi, got.lo, exp.hi, exp.lo);
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    int bc;
    bit tmo;
    for (int i = 0; i < 3; i++) begin
      issue({1'b0, 2'($urandom)}, $urandom, $urandom_range(1, 1 << 20));
      wait_done(got, bc, tmo);
      exp = exp_q.pop_front();
      n_cmp++;
      if (tmo || got !== exp || bc !== 32) begin
        n_err++;
        $display("FAIL b2b_%0d: got hi=%h lo=%h busy_cycles=%0d want hi=%h lo=%h busy_cycles=32",
                 i, got.hi, got.lo, bc, exp.hi, exp.lo);
      end
    end
  endtask

  task automatic test_mt();
    logic [31:0] hv, lv;
    bus.start = 1'b1; bus.op = 3'b100; bus.param1 = 32'hCAFE_0001;
    @(posedge clk); #1 bus.start = 1'b0;
    n_cmp++;
    if (bus.hi !== 32'hCAFE_0001 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL mthi: got hi=%h busy=%b want hi=cafe0001 busy=0", bus.hi, bus.busy);
    end
    bus.start = 1'b1; bus.op = 3'b101; bus.param1 = 32'h0BAD_F00D;
    @(posedge clk); #1 bus.start = 1'b0;
    n_cmp++;
    if (bus.lo !== 32'h0BAD_F00D || bus.hi !== 32'hCAFE_0001 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL mtlo: got hi=%h lo=%h done=%b want hi=cafe0001 lo=0badf00d done=0", bus.hi, bus.lo, bus.done);
    end
    hv = bus.hi;
    lv = bus.lo;
    for (int i = 6; i < 8; i++) begin
      bus.start = 1'b1; bus.op = 3'(i); bus.param1 = 32'h5555_5555;
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.hi !== hv || bus.lo !== lv || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_err++; $display("FAIL reserved_op_%0d: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", i, bus.hi, bus.lo, bus.busy, hv, lv);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int dones;
    bus.start = 1'b1; bus.op = 3'b100; bus.param1 = 32'h1234;
    @(posedge clk); #1 bus.start = 1'b0;
    n_cmp++;
    if (bus.hi !== 32'h1234) begin n_err++; $display("FAIL pre_reset_mthi: got %h want 00001234", bus.hi); end
    issue(3'b000, 32'd6, 32'd7);
    void'(exp_q.pop_back());
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_err++; $display("FAIL midrun_reset: got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_err++; $display("FAIL aborted_done: got %0d pulses want 0", dones); end
    bus.start = 1'b1; bus.op = 3'b101; bus.param1 = 32'hABCD;
    @(posedge clk); #1 bus.start = 1'b0;
    n_cmp++;
    if (bus.lo !== 32'hABCD || bus.busy !== 1'b0 || bus.hi !== 32'd0) begin
      n_err++; $display("FAIL post_reset_mtlo: got lo=%h busy=%b hi=%h want lo=0000abcd busy=0 hi=0", bus.lo, bus.busy, bus.hi);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_divzero();
    test_start_ignored();
    test_back_to_back();
    test_mt();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
